// File: rtl/hemaia_clk_div_sequencer.sv
// Sequences per-domain clock divisor changes: optional domain reset hold, one-cycle
// load pulse, settle wait for the divider period boundary, then reset release and done.

module hemaia_clk_div_sequencer_chk #(
    parameter int NumDomains = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NumDomains-1:0] divisor_valid,
    input  logic                  done
);

    logic prev_done_r;

    // Remember last cycle's done pulse for the back-to-back check
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_done_r <= 1'b0;
        end else begin
            prev_done_r <= done;
        end
    end

    valid_onehot0_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(divisor_valid));

    done_not_consecutive_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(done && prev_done_r));

endmodule

module hemaia_clk_div_sequencer #(
    parameter int NumDomains       = 4,
    parameter int MaxDivisionWidth = 4,
    parameter int DefaultDivision  = 1,
    parameter int RstHoldCycles    = 4,
    parameter int SettleCycles     = 32,
    parameter int DomW             = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    input  logic [DomW-1:0]                       req_domain_i,
    input  logic [MaxDivisionWidth-1:0]           req_divisor_i,
    input  logic                                  req_rst_en_i,
    output logic [NumDomains*MaxDivisionWidth-1:0] divisor_o,
    output logic [NumDomains-1:0]                 divisor_valid_o,
    output logic [NumDomains-1:0]                 domain_rst_no,
    output logic                                  busy_o,
    output logic                                  done_o,
    output logic                                  done_err_o,
    output logic [DomW-1:0]                       done_domain_o
);

    localparam int CntMax = (RstHoldCycles > SettleCycles) ? RstHoldCycles : SettleCycles;
    localparam int CntW   = $clog2(CntMax + 1);
    localparam logic [CntW-1:0]             RstHoldLoad = CntW'(RstHoldCycles - 1);
    localparam logic [CntW-1:0]             SettleLoad  = CntW'(SettleCycles - 1);
    localparam logic [MaxDivisionWidth-1:0] DefDiv      = MaxDivisionWidth'(DefaultDivision);
    localparam logic [DomW:0]               NumDomLim   = (DomW + 1)'(NumDomains);

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ASSERT_RST = 3'd2,
        ST_LOAD       = 3'd3,
        ST_SETTLE     = 3'd4,
        ST_DONE       = 3'd5
    } state_e;

    state_e                      state_r;
    logic [CntW-1:0]             cnt_r;
    logic [DomW-1:0]             dom_r;
    logic [MaxDivisionWidth-1:0] div_cap_r;
    logic [MaxDivisionWidth-1:0] divisor_r [NumDomains];
    logic [NumDomains-1:0]       valid_r;
    logic [NumDomains-1:0]       rstn_r;
    logic                        ready_r;
    logic                        busy_r;
    logic                        done_r;
    logic                        done_err_r;
    logic [DomW-1:0]             done_dom_r;

    logic accept_s;
    logic oob_s;

    // Request handshake and out-of-range domain detection
    always_comb begin
        accept_s = req_valid_i && ready_r;
        oob_s    = ({1'b0, req_domain_i} >= NumDomLim);
    end

    // Sequencer FSM; every output is a register written here
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r    <= ST_INIT;
            cnt_r      <= RstHoldLoad;
            dom_r      <= '0;
            div_cap_r  <= '0;
            for (int d = 0; d < NumDomains; d++) begin
                divisor_r[d] <= DefDiv;
            end
            valid_r    <= '0;
            rstn_r     <= '0;
            ready_r    <= 1'b0;
            busy_r     <= 1'b1;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
            done_dom_r <= '0;
        end else begin
            valid_r    <= '0;
            done_r     <= 1'b0;
            done_err_r <= 1'b0;
            case (state_r)
                ST_INIT: begin
                    if (cnt_r == '0) begin
                        rstn_r  <= '1;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r - CntW'(1);
                    end
                end
                ST_IDLE: begin
                    if (accept_s) begin
                        dom_r     <= req_domain_i;
                        div_cap_r <= req_divisor_i;
                        ready_r   <= 1'b0;
                        busy_r    <= 1'b1;
                        if (oob_s) begin
                            // Rejected: acknowledge without touching any divider or reset
                            done_r     <= 1'b1;
                            done_err_r <= 1'b1;
                            done_dom_r <= req_domain_i;
                            state_r    <= ST_DONE;
                        end else if (req_rst_en_i) begin
                            rstn_r[req_domain_i] <= 1'b0;
                            cnt_r                <= RstHoldLoad;
                            state_r              <= ST_ASSERT_RST;
                        end else begin
                            divisor_r[req_domain_i] <= req_divisor_i;
                            valid_r[req_domain_i]   <= 1'b1;
                            state_r                 <= ST_LOAD;
                        end
                    end
                end
                ST_ASSERT_RST: begin
                    if (cnt_r == '0) begin
                        divisor_r[dom_r] <= div_cap_r;
                        valid_r[dom_r]   <= 1'b1;
                        state_r          <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r - CntW'(1);
                    end
                end
                ST_LOAD: begin
                    cnt_r   <= SettleLoad;
                    state_r <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_r == '0) begin
                        rstn_r[dom_r] <= 1'b1;
                        done_r        <= 1'b1;
                        done_dom_r    <= dom_r;
                        state_r       <= ST_DONE;
                    end else begin
                        cnt_r <= cnt_r - CntW'(1);
                    end
                end
                ST_DONE: begin
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    // Illegal encoding: restart the power-up sequence
                    cnt_r   <= RstHoldLoad;
                    rstn_r  <= '0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

    for (genvar d = 0; d < NumDomains; d++) begin : g_div_out
        assign divisor_o[d*MaxDivisionWidth +: MaxDivisionWidth] = divisor_r[d];
    end

    assign divisor_valid_o = valid_r;
    assign domain_rst_no   = rstn_r;
    assign req_ready_o     = ready_r;
    assign busy_o          = busy_r;
    assign done_o          = done_r;
    assign done_err_o      = done_err_r;
    assign done_domain_o   = done_dom_r;

    hemaia_clk_div_sequencer_chk #(
        .NumDomains(NumDomains)
    ) u_chk (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .divisor_valid(valid_r),
        .done         (done_r)
    );

endmodule

// File: doc/hemaia_clk_div_sequencer.md
Name: hemaia_clk_div_sequencer

Overview:
- Sequences divisor changes for `NumDomains` per-domain clock dividers, one request at a time.
- For each accepted request it optionally holds the target domain in reset, presents the new divisor with a one-cycle valid pulse, and waits long enough for the divider to pick the divisor up at its next period boundary.
- It then releases the domain reset and reports completion.
- It sits between the clock/reset CSR front-end and the divider instances in the clock/reset controller.

Parameters:
- NumDomains, 4, number of divided clock domains controlled (>=1).
- MaxDivisionWidth, 4, divisor width; matches the divider instances.
- DefaultDivision, 1, per-domain divisor value after reset.
- RstHoldCycles, 4, cycles the domain reset is held before the divisor is loaded (>=1).
- SettleCycles, 32, cycles waited after the load pulse. Must be >= 2*2^MaxDivisionWidth.
- DomW, max(1,$clog2(NumDomains)), derived domain-index width.

Ports:
- clk_i  in  1  controller clock; same clock as the dividers' clk_i.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  change request valid.
- req_ready_o  out  1  request can be accepted.
- req_domain_i  in  DomW  target domain index.
- req_divisor_i  in  MaxDivisionWidth  new divisor; 0 gates the domain clock.
- req_rst_en_i  in  1  hold the domain reset during the change.
- divisor_o  out  NumDomains*MaxDivisionWidth  per-domain divisor; slice d drives divider d.
- divisor_valid_o  out  NumDomains  one-hot load pulse per domain.
- domain_rst_no  out  NumDomains  per-domain active-low reset.
- busy_o  out  1  sequence in progress (state != IDLE).
- done_o  out  1  one-cycle completion pulse.
- done_err_o  out  1  qualifies done_o; the request was rejected.
- done_domain_o  out  DomW  domain of the completed request.

Behaviour:
- Clock and reset: one clock, `clk_i`; reset `rst_ni` is asynchronous and active-low. All state and outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- Reset values:
  - FSM = INIT.
  - divisor_o = DefaultDivision in every slice.
  - divisor_valid_o = 0.
  - domain_rst_no = all 0 (asserted).
  - req_ready_o = 0, done_o = 0, done_err_o = 0, done_domain_o = 0, busy_o = 1.
- FSM states: INIT, IDLE, ASSERT_RST, LOAD, SETTLE, DONE.
- INIT: stays RstHoldCycles cycles, then drives domain_rst_no = all 1 and goes to IDLE. Requests are not accepted in INIT.
- IDLE:
  - req_ready_o = 1. A request is accepted on the edge where req_valid_i && req_ready_o.
  - On acceptance, domain, divisor and rst_en are captured. Inputs are ignored outside the accept edge.
  - If domain >= NumDomains: go to DONE with done_err_o = 1. No divider or reset output is touched.
  - Else if rst_en = 1: go to ASSERT_RST. Else: go to LOAD.
- ASSERT_RST: domain_rst_no[d] = 0 for RstHoldCycles cycles, then go to LOAD.
- LOAD (1 cycle):
  - divisor_o slice d = captured divisor and divisor_valid_o[d] = 1. Only bit d is high.
  - Other slices hold their values. Go to SETTLE.
- SETTLE: SettleCycles cycles, then go to DONE. domain_rst_no[d] stays 0 if rst_en, else 1.
- DONE (1 cycle):
  - done_o = 1 and done_domain_o = captured domain.
  - domain_rst_no[d] = 1 from this cycle.
  - Go to IDLE.
- Latency, counting cycle 1 as the cycle after the accept edge:
  - rst_en = 1: ASSERT_RST cycles 1..RstHoldCycles, LOAD at RstHoldCycles+1, done_o at RstHoldCycles+SettleCycles+2. Defaults: 4+32+2 = 38.
  - rst_en = 0: done_o at SettleCycles+2 = 34.
  - Error request: done_o at cycle 1.
  - req_ready_o returns high the cycle after DONE.
- A single down-counter is shared by INIT, ASSERT_RST and SETTLE. Width is $clog2(max(RstHoldCycles,SettleCycles)+1). It is reloaded on every state entry.
- Boundary conditions:
  - A divisor equal to the current value is still fully sequenced.
  - Divisor 0 is legal and gates the domain clock.
  - req_valid_i held high back-to-back: a new request is accepted only in IDLE, one per sequence.
  - Reset asserted mid-sequence: all outputs take reset values immediately and asynchronously; the sequence is discarded and nothing is acknowledged.
- Assertions:
  - divisor_valid_o is one-hot-or-zero.
  - done_o is never high on consecutive cycles.

Test Plan:
- Reset release -> domain_rst_no = 0000 for 4 cycles, then 1111. req_ready_o rises in the same cycle domain_rst_no goes to 1111. Every divisor_o slice = 1.
- Request domain 2, divisor 6, rst_en = 1 -> domain_rst_no[2] low for cycles 1..37. divisor_valid_o = 0100 at cycle 5 only. done_o and domain_rst_no[2] high at cycle 38. divisor_o slice 2 = 6; other slices unchanged. The divided clock on domain 2 measures period 6 after done_o.
- Request domain 0, divisor 3, rst_en = 0 -> domain_rst_no stays 1111. divisor_valid_o = 0001 at cycle 1. done_o at cycle 34 with done_err_o = 0.
- NumDomains = 3, request domain 3 -> done_o and done_err_o at cycle 1. No valid pulse; all divisor_o and domain_rst_no unchanged.
- req_valid_i held high with two queued requests -> second request accepted only the cycle after the first done_o. busy_o is low for exactly that one cycle between the two sequences.
- rst_ni asserted during SETTLE -> same-cycle return to reset values: domain_rst_no = 0000, divisor_o = DefaultDivision. No done_o is produced. The INIT sequence reruns after release.
